// File: rtl/board_write_ctrl.sv
// rtl/board_write_ctrl.sv - checkerboard RAM write-port owner: CLEAR sweep, PLACE, UNDO with move stack
module board_write_ctrl #(
  parameter int EDGE_ADDR_BITS = 3,
  parameter int DATA_BITS      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [2*EDGE_ADDR_BITS-1:0]   cmd_pos,
  input  logic                          cmd_color,
  output logic                          ram_we,
  output logic [2*EDGE_ADDR_BITS-1:0]   ram_wr_addr,
  output logic [DATA_BITS-1:0]          ram_wr_data,
  output logic [2*EDGE_ADDR_BITS:0]     piece_count,
  output logic [2*EDGE_ADDR_BITS-1:0]   undone_pos,
  output logic                          done,
  output logic                          err
);

  localparam int PW    = 2 * EDGE_ADDR_BITS;
  localparam int CW    = PW + 1;
  localparam int CELLS = 1 << PW;
  localparam logic [CW-1:0] FULL = CW'(CELLS);

  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_PLACE = 2'b10;
  localparam logic [1:0] OP_UNDO  = 2'b11;

  localparam logic [DATA_BITS-1:0] RED   = DATA_BITS'(1);
  localparam logic [DATA_BITS-1:0] GREEN = DATA_BITS'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_PLACE, S_UNDO_RD, S_UNDO_WR, S_FIN
  } state_t;

  state_t                 state_q;
  logic                   ram_we_q;
  logic [PW-1:0]          ram_wr_addr_q;
  logic [DATA_BITS-1:0]   ram_wr_data_q;
  logic [CW-1:0]          piece_count_q;
  logic [PW-1:0]          undone_pos_q;
  logic                   done_q;
  logic                   err_q;
  logic [CW-1:0]          clr_cnt_q;
  logic [PW-1:0]          pop_q;
  logic [PW-1:0]          stack_q [CELLS];

  logic                   accept_d;
  logic                   push_d;
  logic [PW-1:0]          top_idx_d;

  // piece_count doubles as the move-stack pointer: entry i holds the (i+1)-th placed cell
  assign cmd_ready = (state_q == S_IDLE);
  assign accept_d  = cmd_valid & cmd_ready;
  assign push_d    = accept_d && (cmd_op == OP_PLACE) && (piece_count_q != FULL);
  assign top_idx_d = piece_count_q[PW-1:0] - PW'(1);

  assign ram_we      = ram_we_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign piece_count = piece_count_q;
  assign undone_pos  = undone_pos_q;
  assign done        = done_q;
  assign err         = err_q;

  // Move-history stack: push on accepted PLACE, synchronous pop read in UNDO_RD
  always_ff @(posedge clk) begin
    if (push_d) stack_q[piece_count_q[PW-1:0]] <= cmd_pos;
    if (state_q == S_UNDO_RD) pop_q <= stack_q[top_idx_d];
  end

  // Command sequencer with registered RAM write port and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ram_we_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      piece_count_q <= '0;
      undone_pos_q  <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      clr_cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            case (cmd_op)
              OP_CLEAR: begin
                clr_cnt_q <= '0;
                state_q   <= S_CLEAR;
              end
              OP_PLACE: begin
                if (piece_count_q == FULL) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_FIN;
                end else begin
                  ram_we_q      <= 1'b1;
                  ram_wr_addr_q <= cmd_pos;
                  ram_wr_data_q <= cmd_color ? GREEN : RED;
                  piece_count_q <= piece_count_q + CW'(1);
                  state_q       <= S_PLACE;
                end
              end
              OP_UNDO: begin
                if (piece_count_q == '0) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  state_q <= S_FIN;
                end else begin
                  state_q <= S_UNDO_RD;
                end
              end
              default: ;
            endcase
          end
        end
        S_CLEAR: begin
          // counter is one bit wider than the address so it stops after the last cell instead of wrapping
          if (clr_cnt_q == FULL) begin
            ram_we_q      <= 1'b0;
            piece_count_q <= '0;
            done_q        <= 1'b1;
            state_q       <= S_FIN;
          end else begin
            ram_we_q      <= 1'b1;
            ram_wr_addr_q <= clr_cnt_q[PW-1:0];
            ram_wr_data_q <= '0;
            clr_cnt_q     <= clr_cnt_q + CW'(1);
          end
        end
        S_PLACE: begin
          ram_we_q <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_FIN;
        end
        S_UNDO_RD: begin
          state_q <= S_UNDO_WR;
        end
        S_UNDO_WR: begin
          // first cycle issues the erase write, second cycle releases it
          if (!ram_we_q) begin
            ram_we_q      <= 1'b1;
            ram_wr_addr_q <= pop_q;
            ram_wr_data_q <= '0;
            undone_pos_q  <= pop_q;
            piece_count_q <= piece_count_q - CW'(1);
          end else begin
            ram_we_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_write_ctrl.sv
// tb/tb_board_write_ctrl.sv - directed self-checking bench for board_write_ctrl
module tb_board_write_ctrl;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_PLACE = 2'b10;
  localparam logic [1:0] OP_UNDO  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [5:0] cmd_pos;
  logic       cmd_color;
  logic       ram_we;
  logic [5:0] ram_wr_addr;
  logic [1:0] ram_wr_data;
  logic [6:0] piece_count;
  logic [5:0] undone_pos;
  logic       done;
  logic       err;

  board_write_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pos(cmd_pos), .cmd_color(cmd_color),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .piece_count(piece_count), .undone_pos(undone_pos), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] wa_q [$];
  logic [1:0] wd_q [$];
  int         wc_q [$];
  always @(negedge clk) begin
    if (ram_we) begin
      wa_q.push_back(ram_wr_addr);
      wd_q.push_back(ram_wr_data);
      wc_q.push_back(cyc);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  // lat = index of the clock edge at which done is sampled high, counted from the accept edge
  task automatic run_cmd(input logic [1:0] op, input logic [5:0] pos, input logic color,
                         output int lat, output logic e);
    int t0, n;
    n = 0;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    clear_log();
    cmd_op = op; cmd_pos = pos; cmd_color = color; cmd_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    cmd_valid = 1'b0;
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    check("done_seen", {31'd0, done}, 32'd1);
    lat = cyc + 1 - t0;
    e = err;
    @(negedge clk);
  endtask

  int   lat, n, bad, tot_w, errs, t0, nz;
  logic e;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_pos = '0; cmd_color = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_addr", {26'd0, ram_wr_addr}, 32'd0);
    check("rst_count", {25'd0, piece_count}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // NOP: no done, no write
    clear_log();
    cmd_op = OP_NOP; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (3) begin
      check("nop_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    check("nop_writes", wa_q.size(), 32'd0);

    // 1. PLACE 1B red
    run_cmd(OP_PLACE, 6'h1B, 1'b0, lat, e);
    check("p1_lat", lat, 32'd2);
    check("p1_err", {31'd0, e}, 32'd0);
    check("p1_writes", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check("p1_addr", {26'd0, wa_q[0]}, 32'h1B);
      check("p1_data", {30'd0, wd_q[0]}, 32'h1);
    end
    check("p1_count", {25'd0, piece_count}, 32'd1);

    // 2. PLACE 05 green, then UNDO twice
    run_cmd(OP_PLACE, 6'h05, 1'b1, lat, e);
    check("p2_data", (wd_q.size() > 0) ? {30'd0, wd_q[0]} : 32'hFF, 32'h2);
    check("p2_count", {25'd0, piece_count}, 32'd2);
    run_cmd(OP_UNDO, 6'h3F, 1'b0, lat, e);
    check("u1_lat", lat, 32'd4);
    check("u1_err", {31'd0, e}, 32'd0);
    check("u1_writes", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check("u1_addr", {26'd0, wa_q[0]}, 32'h05);
      check("u1_data", {30'd0, wd_q[0]}, 32'h0);
    end
    check("u1_undone", {26'd0, undone_pos}, 32'h05);
    check("u1_count", {25'd0, piece_count}, 32'd1);
    run_cmd(OP_UNDO, 6'h00, 1'b0, lat, e);
    check("u2_undone", {26'd0, undone_pos}, 32'h1B);
    check("u2_count", {25'd0, piece_count}, 32'd0);

    // 3. UNDO on empty board
    run_cmd(OP_UNDO, 6'h00, 1'b0, lat, e);
    check("u3_lat", lat, 32'd1);
    check("u3_err", {31'd0, e}, 32'd1);
    check("u3_writes", wa_q.size(), 32'd0);
    check("u3_count", {25'd0, piece_count}, 32'd0);
    check("u3_undone_held", {26'd0, undone_pos}, 32'h1B);

    // 4. fill the board, overflow, then CLEAR
    tot_w = 0; errs = 0; bad = 0;
    for (int i = 0; i < 64; i++) begin
      run_cmd(OP_PLACE, 6'(i), i[0], lat, e);
      tot_w += wa_q.size();
      errs  += int'(e);
      if (wa_q.size() != 1) bad++;
      else if (wa_q[0] != 6'(i) || wd_q[0] != (i[0] ? 2'b10 : 2'b01)) bad++;
    end
    check("fill_writes", tot_w, 32'd64);
    check("fill_errs", errs, 32'd0);
    check("fill_bad", bad, 32'd0);
    check("fill_count", {25'd0, piece_count}, 32'd64);
    run_cmd(OP_PLACE, 6'h10, 1'b1, lat, e);
    check("ovf_err", {31'd0, e}, 32'd1);
    check("ovf_lat", lat, 32'd1);
    check("ovf_writes", wa_q.size(), 32'd0);
    check("ovf_count", {25'd0, piece_count}, 32'd64);
    run_cmd(OP_UNDO, 6'h00, 1'b0, lat, e);
    check("full_undo_addr", (wa_q.size() > 0) ? {26'd0, wa_q[0]} : 32'hFF, 32'h3F);
    check("full_undo_count", {25'd0, piece_count}, 32'd63);
    run_cmd(OP_CLEAR, 6'h00, 1'b0, lat, e);
    check("clr_lat", lat, 32'd66);
    check("clr_err", {31'd0, e}, 32'd0);
    check("clr_writes", wa_q.size(), 32'd64);
    bad = 0;
    if (wa_q.size() == 64) begin
      for (int i = 0; i < 64; i++)
        if (wa_q[i] != 6'(i) || wd_q[i] != 2'b00) bad++;
      check("clr_consecutive", wc_q[63] - wc_q[0], 32'd63);
    end else bad = 99;
    check("clr_order", bad, 32'd0);
    check("clr_count", {25'd0, piece_count}, 32'd0);
    run_cmd(OP_UNDO, 6'h00, 1'b0, lat, e);
    check("clr_then_undo_err", {31'd0, e}, 32'd1);

    // 5. reset in the middle of a CLEAR
    for (int i = 0; i < 3; i++) run_cmd(OP_PLACE, 6'(i + 8), 1'b0, lat, e);
    clear_log();
    cmd_op = OP_CLEAR; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    n = 0;
    while (!(ram_we && ram_wr_addr == 6'd20) && n < 200) begin @(negedge clk); n++; end
    check("mid_addr20", {26'd0, ram_wr_addr}, 32'd20);
    check("mid_count", {25'd0, piece_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, ram_we}, 32'd0);
    check("mid_rst_addr", {26'd0, ram_wr_addr}, 32'd0);
    check("mid_rst_count", {25'd0, piece_count}, 32'd0);
    check("mid_rst_undone", {26'd0, undone_pos}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", {31'd0, cmd_ready}, 32'd1);
    run_cmd(OP_UNDO, 6'h00, 1'b0, lat, e);
    check("mid_undo_err", {31'd0, e}, 32'd1);

    // 6. PLACE held on the command port throughout a CLEAR
    clear_log();
    cmd_op = OP_CLEAR; cmd_valid = 1'b1;
    @(negedge clk);
    t0 = cyc;
    cmd_op = OP_PLACE; cmd_pos = 6'h2A; cmd_color = 1'b1;
    n = 0;
    while (!done && n < 300) begin @(negedge clk); n++; end
    check("hold_clr_lat", cyc + 1 - t0, 32'd66);
    @(negedge clk);
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    check("hold_place_done", {31'd0, done}, 32'd1);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_writes", wa_q.size(), 32'd65);
    nz = 0;
    foreach (wd_q[i]) if (wd_q[i] != 2'b00) nz++;
    check("hold_place_once", nz, 32'd1);
    if (wa_q.size() > 0) begin
      check("hold_last_addr", {26'd0, wa_q[wa_q.size()-1]}, 32'h2A);
      check("hold_last_data", {30'd0, wd_q[wd_q.size()-1]}, 32'h2);
    end
    check("hold_count", {25'd0, piece_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
